// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes and the datapath select codes driven by multicycle_controller.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_A     = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRCB_WD   = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic imm_src_e imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU operation decoder: turns the FSM's ALUOp plus the instruction's funct
// fields into the 3-bit ALUControl code.
module aludec
    import riscv_mc_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);

    logic r_type_sub;

    // I-type addi shares funct3 000 with sub; only R-type honours funct7b5.
    assign r_type_sub = opb5 & funct7b5;

    // NOTE: every path assigns ALUControl (default arm included), so no latch is inferred.
    always_comb begin
        case (ALUOp)
            2'b00: ALUControl = ALU_ADD;
            2'b01: ALUControl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = r_type_sub ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM of the multicycle RV32I core: sequences fetch, decode and
// execute, drives datapath selects/strobes and stalls on mem_ready.
module multicycle_controller
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_op
);

    state_e      state_q, state_d;
    aluop_e      alu_op;
    result_src_e result_src;
    alu_src_a_e  src_a;
    alu_src_b_e  src_b;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_WD;
        alu_op     = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                src_b      = SRCB_FOUR;
                result_src = RES_ALURESULT;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // OldPC + ImmExt lands in ALUOut as the branch target.
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = SRCA_A;
                src_b   = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                src_a   = SRCA_A;
                src_b   = SRCB_WD;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                src_a   = SRCA_A;
                src_b   = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                src_a    = SRCA_A;
                src_b    = SRCB_WD;
                alu_op   = ALUOP_SUB;
                pc_write = Zero;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                src_a    = SRCA_OLDPC;
                src_b    = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are masked by reset_n so nothing writes while reset is held,
    // even though FETCH would otherwise fire on mem_ready.
    assign PCWrite    = pc_write  & reset_n;
    assign IRWrite    = ir_write  & reset_n;
    assign MemWrite   = mem_write & reset_n;
    assign RegWrite   = reg_write & reset_n;
    assign illegal_op = illegal   & reset_n;
    assign AdrSrc     = adr_src;
    assign ResultSrc  = result_src;
    assign ALUSrcA    = src_a;
    assign ALUSrcB    = src_b;
    assign ImmSrc     = imm_src_of(op);

    aludec u_aludec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUOp      (alu_op),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction step plans
// built from the instruction class, compared cycle by cycle against the DUT.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw, ill;
        logic [1:0] res, sa, sb, imm;
        logic [2:0] alu;
    } outs_t;

    typedef enum {P_FETCH, P_DECODE, P_ADDR, P_LOAD, P_LOADWB, P_STORE,
                  P_EXR, P_EXI, P_WB, P_BRANCH, P_JUMP} phase_e;

    bit   directed = 1'b1;
    bit   zero_fix = 1'b0;
    bit   ready_q[$];

    function automatic outs_t observed();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
    endfunction

    // kind: 0 add, 1 subtract, 2 decode from funct fields
    function automatic logic [2:0] alu_expect(input int kind, input logic [6:0] o,
                                              input logic [2:0] f3, input logic f7);
        if (kind == 0) return 3'b000;
        if (kind == 1) return 3'b001;
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic outs_t expect_row(input phase_e p, input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7, input logic rdy, input logic z);
        outs_t e;
        e     = '0;
        e.imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        e.alu = alu_expect(0, o, f3, f7);
        case (p)
            P_FETCH:  begin e.pcw = rdy; e.irw = rdy; e.sb = 2'b10; e.res = 2'b10; end
            P_DECODE: begin e.sa = 2'b01; e.sb = 2'b01; e.ill = !is_legal(o); end
            P_ADDR:   begin e.sa = 2'b10; e.sb = 2'b01; end
            P_LOAD:   e.adr = 1'b1;
            P_LOADWB: begin e.res = 2'b01; e.regw = 1'b1; end
            P_STORE:  begin e.adr = 1'b1; e.memw = 1'b1; end
            P_EXR:    begin e.sa = 2'b10; e.alu = alu_expect(2, o, f3, f7); end
            P_EXI:    begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_expect(2, o, f3, f7); end
            P_WB:     e.regw = 1'b1;
            P_BRANCH: begin e.sa = 2'b10; e.alu = alu_expect(1, o, f3, f7); e.pcw = z; end
            P_JUMP:   begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the instruction's last cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             output int n_regw, output int n_memw, output int n_cyc);
        phase_e plan[$];
        int     idx;
        outs_t  exp_o;
        plan = '{P_FETCH, P_DECODE};
        case (o)
            LW:      plan = {plan, P_ADDR, P_LOAD, P_LOADWB};
            SW:      plan = {plan, P_ADDR, P_STORE};
            RT:      plan = {plan, P_EXR, P_WB};
            IT:      plan = {plan, P_EXI, P_WB};
            BQ:      plan.push_back(P_BRANCH);
            JL:      plan = {plan, P_JUMP, P_WB};
            default: ;
        endcase
        op = o; funct3 = f3; funct7b5 = f7;
        idx = 0; n_regw = 0; n_memw = 0; n_cyc = 0;
        while (idx < plan.size()) begin
            if (directed) begin
                mem_ready = (ready_q.size() > 0) ? ready_q.pop_front() : 1'b1;
                Zero      = zero_fix;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
                Zero      = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            exp_o = expect_row(plan[idx], o, f3, f7, mem_ready, Zero);
            check($sformatf("op%07b_%s", o, plan[idx].name()), 32'(observed()), 32'(exp_o));
            n_regw += int'(RegWrite);
            n_memw += int'(MemWrite);
            n_cyc++;
            if (!((plan[idx] == P_FETCH || plan[idx] == P_LOAD || plan[idx] == P_STORE) && !mem_ready))
                idx++;
            @(posedge clk);
            #1;
        end
    endtask

    int nr, nm, nc;

    initial begin
        reset_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0;
        op = RT; funct3 = 3'b000; funct7b5 = 1'b0;
        #2;
        check("rst_pcwrite", 32'(PCWrite), 32'd0);
        check("rst_irwrite", 32'(IRWrite), 32'd0);
        check("rst_alusrcb", 32'(ALUSrcB), 32'd2);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_row", 32'(observed()),
              32'(expect_row(P_FETCH, RT, 3'b000, 1'b0, 1'b0, 1'b0)));
        reset_n = 1'b1;

        run_instr(RT, 3'b000, 1'b1, nr, nm, nc);
        check("rsub_regwrite_cnt", 32'(nr), 32'd1);
        check("rsub_cycles", 32'(nc), 32'd4);

        ready_q = '{1, 1, 1, 0, 0, 1, 1};
        run_instr(LW, 3'b010, 1'b0, nr, nm, nc);
        check("lw_regwrite_cnt", 32'(nr), 32'd1);
        check("lw_cycles", 32'(nc), 32'd7);

        ready_q = '{1, 1, 1, 0, 1};
        run_instr(SW, 3'b010, 1'b0, nr, nm, nc);
        check("sw_memwrite_cnt", 32'(nm), 32'd2);
        check("sw_cycles", 32'(nc), 32'd5);

        zero_fix = 1'b1;
        run_instr(BQ, 3'b000, 1'b0, nr, nm, nc);
        zero_fix = 1'b0;
        run_instr(BQ, 3'b000, 1'b0, nr, nm, nc);
        run_instr(IT, 3'b000, 1'b1, nr, nm, nc);
        run_instr(JL, 3'b000, 1'b0, nr, nm, nc);
        check("jal_regwrite_cnt", 32'(nr), 32'd1);
        run_instr(7'b1111111, 3'b000, 1'b0, nr, nm, nc);
        check("illegal_write_cnt", 32'(nr + nm), 32'd0);

        // Drop reset while a store is stalled: MemWrite must fall without an edge.
        op = SW; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_memwrite", 32'(MemWrite), 32'd1);
        #1;
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("async_rst_memwrite", 32'(MemWrite), 32'd0);
        check("async_rst_row", 32'(observed()),
              32'(expect_row(P_FETCH, SW, 3'b010, 1'b0, 1'b0, 1'b0)));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        directed = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            int         pick;
            pick = $urandom_range(0, 6);
            case (pick)
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = IT;
                4: o = BQ;
                5: o = JL;
                default: begin
                    o = 7'b1111111;
                    for (int t = 0; t < 16; t++) begin
                        o = 7'($urandom);
                        if (!is_legal(o)) break;
                    end
                    if (is_legal(o)) o = 7'b1111111;
                end
            endcase
            run_instr(o, 3'($urandom), 1'($urandom), nr, nm, nc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core: a single shared ALU, a unified instruction/data memory and non-architectural registers (IR, OldPC, A, WriteData, ALUOut, Data) in place of the single-cycle datapath's dedicated adders. It sequences each instruction through fetch, decode and execute states, and drives the datapath's mux selects and write strobes each cycle. It stalls on a memory-ready handshake. Supported instructions are lw, sw, R-type ALU, I-type ALU, beq and jal; any other opcode is flagged and skipped.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_op  out  1  one-cycle pulse, unsupported opcode

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.
- Moore FSM. Outputs are combinational from state; mem_ready and Zero gate strobes as noted. Unlisted strobes are 0. Unlisted selects are 00.
- ImmSrc decodes from op in every state: sw 01, beq 10, jal 11, else 00.
- ALUOp is internal. 00 gives add, 01 gives sub, 10 uses funct decode.
- FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10.
  - IRWrite and PCWrite are asserted only when mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00, which precomputes the branch target into ALUOut.
  - Next state by op: lw/sw to MEMADR, R to EXECUTER, I to EXECUTEI, beq to BEQ, jal to JAL.
  - Any other op goes to FETCH with illegal_op=1.
- MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00. Goes to MEMREAD if op is lw, MEMWRITE if op is sw.
- MEMREAD: AdrSrc 1, ResultSrc 00. Goes to MEMWB on mem_ready, else holds.
- MEMWB: ResultSrc 01, RegWrite. Goes to FETCH.
- MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite held every cycle. Goes to FETCH on mem_ready.
- EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10. Goes to ALUWB.
- EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10. Goes to ALUWB.
- ALUWB: ResultSrc 00, RegWrite. Goes to FETCH.
- BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, PCWrite=Zero. Goes to FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCWrite. Goes to ALUWB, which writes PC+4 to rd.
- ALU decode:
  - ALUOp 10 with funct3 000 gives sub only if R-type (op[5]=1) and funct7b5=1; otherwise add.
  - funct3 010 gives slt, 110 gives or, 111 gives and.
  - Any other funct3 gives add.

## Timing
- Reset: state is FETCH asynchronously on reset_n=0. While reset_n=0, all strobes (PCWrite, IRWrite, MemWrite, RegWrite, illegal_op) are 0 and the selects show FETCH values. The first fetch can complete on the first rising edge after release.
- Reset mid-instruction aborts it immediately. No partial write occurs after the reset assertion.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. All outputs stay stable during the stall.
- mem_ready is ignored in all other states.

## Structure
- Package riscv_mc_pkg holds:
  - the state enum (11 states),
  - opcode constants,
  - ALUOp, ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings.
- Sub-module: reuse the existing aludec (opb5, funct3, funct7b5, ALUOp, ALUControl) unchanged.
- Next-state and output logic live in multicycle_controller.

## Test plan
- Reset: hold reset_n=0 with mem_ready=1 -> PCWrite=IRWrite=0, ALUSrcB=10. Release -> the first edge enters DECODE.
- R-type sub (op 0110011, funct3 000, funct7b5 1), mem_ready=1 -> states F,D,EXECUTER,ALUWB. ALUControl=001 in EXECUTER. RegWrite only in cycle 4.
- lw with mem_ready=0 for 2 cycles in MEMREAD -> total 7 cycles. RegWrite with ResultSrc=01 exactly once.
- sw with mem_ready low for 1 cycle -> MemWrite high for 2 cycles with AdrSrc=1. 5 cycles total.
- beq: Zero=1 -> PCWrite=1 in BEQ with ALUControl=001. Zero=0 -> PCWrite=0. Both cases take 3 cycles.
- op 1111111 -> illegal_op pulses in DECODE, returns to FETCH, no write strobes asserted. Separately, reset_n dropped in MEMWRITE -> MemWrite falls without a clock edge.
